// File: rtl/store_buffer.sv
// In-order store buffer between the MEM-stage store path and the data memory.
// Drains one entry per cycle and forwards word data (or stalls) for loads that hit.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_pc,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic             st_byte,
  input  logic             drain_hold,
  output logic             dm_we,
  output logic [31:0]      dm_pc,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wd,
  output logic [1:0]       dm_op,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  output logic [31:0]      ld_data,
  output logic             ld_stall,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  logic [31:0] pc_q   [DEPTH];
  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic        byte_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  assign empty    = (count == '0);
  assign st_ready = (count != (PTR_W+1)'(DEPTH));
  assign push     = st_valid && st_ready;
  assign pop      = !empty && !drain_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Entry payload needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= st_pc;
      addr_q[wr_ptr] <= st_addr;
      data_q[wr_ptr] <= st_data;
      byte_q[wr_ptr] <= st_byte;
    end
  end

  always_comb begin
    dm_we   = pop;
    dm_pc   = '0;
    dm_addr = '0;
    dm_wd   = '0;
    dm_op   = '0;
    if (!empty) begin
      dm_pc   = pc_q[rd_ptr];
      dm_addr = addr_q[rd_ptr];
      dm_wd   = data_q[rd_ptr];
      dm_op   = {1'b0, byte_q[rd_ptr]};
    end
  end

  // Walk oldest to youngest so the last match found is the youngest.
  logic             match;
  logic [PTR_W-1:0] match_idx;
  logic [PTR_W-1:0] idx;

  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((PTR_W+1)'(i) < count && addr_q[idx][31:2] == ld_addr[31:2]) begin
        match     = 1'b1;
        match_idx = idx;
      end
    end
  end

  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = '0;
    if (ld_valid && match) begin
      if (byte_q[match_idx]) begin
        ld_stall = 1'b1;
      end else begin
        ld_hit  = 1'b1;
        ld_data = data_q[match_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             st_valid, st_ready, st_byte, drain_hold;
  logic [31:0]      st_pc, st_addr, st_data;
  logic             dm_we;
  logic [31:0]      dm_pc, dm_addr, dm_wd;
  logic [1:0]       dm_op;
  logic             ld_valid, ld_hit, ld_stall;
  logic [31:0]      ld_addr, ld_data;
  logic [PTR_W:0]   count;
  logic             empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        b;
  } ent_t;

  ent_t q[$];
  logic exp_ready, exp_we;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_pc(st_pc), .st_addr(st_addr),
    .st_data(st_data), .st_byte(st_byte), .drain_hold(drain_hold),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_op(dm_op),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .ld_stall(ld_stall), .count(count), .empty(empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the queue contents and current inputs.
  task automatic check_outputs();
    logic        hit, stall;
    logic [31:0] ldd;
    hit = 1'b0; stall = 1'b0; ldd = '0;
    exp_ready = (q.size() < DEPTH);
    exp_we    = (q.size() != 0) && !drain_hold;
    if (ld_valid) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].addr[31:2] == ld_addr[31:2]) begin
          if (q[i].b) stall = 1'b1;
          else begin hit = 1'b1; ldd = q[i].data; end
          break;
        end
      end
    end
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("st_ready", 32'(st_ready), 32'(exp_ready));
    chk("dm_we", 32'(dm_we), 32'(exp_we));
    chk("dm_pc", dm_pc, q.size() != 0 ? q[0].pc : 32'h0);
    chk("dm_addr", dm_addr, q.size() != 0 ? q[0].addr : 32'h0);
    chk("dm_wd", dm_wd, q.size() != 0 ? q[0].data : 32'h0);
    chk("dm_op", 32'(dm_op), q.size() != 0 ? 32'(q[0].b) : 32'h0);
    chk("ld_hit", 32'(ld_hit), 32'(hit));
    chk("ld_stall", 32'(ld_stall), 32'(stall));
    chk("ld_data", ld_data, ldd);
  endtask

  // Called at posedge+1: drive, check at the falling edge, then apply the edge to the model.
  task automatic cycle(input logic sv, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] d, input logic b, input logic hold,
                       input logic lv, input logic [31:0] la);
    ent_t e;
    st_valid = sv; st_pc = pc; st_addr = a; st_data = d; st_byte = b;
    drain_hold = hold; ld_valid = lv; ld_addr = la;
    #4;
    check_outputs();
    @(posedge clk);
    if (exp_we) void'(q.pop_front());
    if (sv && exp_ready) begin
      e.pc = pc; e.addr = a; e.data = d; e.b = b;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic hold);
    cycle(1'b0, '0, '0, '0, 1'b0, hold, 1'b0, '0);
  endtask

  initial begin
    st_valid = 0; st_pc = '0; st_addr = '0; st_data = '0; st_byte = 0;
    drain_hold = 0; ld_valid = 0; ld_addr = '0;
    reset = 1'b0;
    #12;
    check_outputs();
    reset = 1'b1;
    @(posedge clk); #1;

    // Single word store: visible next cycle, drained the one after.
    cycle(1, 32'h3000, 32'h10, 32'hDEADBEEF, 0, 0, 0, '0);
    chk("sw_dm_we", 32'(dm_we), 32'h1);
    chk("sw_dm_wd", dm_wd, 32'hDEADBEEF);
    idle(0);
    idle(0);
    chk("sw_empty_after", 32'(empty), 32'h1);

    // Fill under hold, try a fifth store, then drain in order.
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h100 + 32'(i*4), 32'h40 + 32'(i*4), 32'hA0 + 32'(i), 0, 1, 0, '0);
    chk("full_count", 32'(count), 32'd4);
    cycle(1, 32'h200, 32'h80, 32'hBAD, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++) idle(0);
    idle(0);

    // Full with drain active while a store waits: accepted the following cycle.
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h300 + 32'(i), 32'h60 + 32'(i*4), 32'hC0 + 32'(i), 0, 1, 0, '0);
    cycle(1, 32'h3FF, 32'h90, 32'h55AA55AA, 0, 0, 0, '0);
    cycle(1, 32'h3FF, 32'h90, 32'h55AA55AA, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) idle(0);

    // Youngest word match forwards.
    cycle(1, 32'h400, 32'h20, 32'h11111111, 0, 1, 0, '0);
    cycle(1, 32'h404, 32'h20, 32'h22222222, 0, 1, 0, '0);
    cycle(0, '0, '0, '0, 0, 1, 1, 32'h23);
    chk("fwd_ld_data", ld_data, 32'h22222222);
    for (int i = 0; i < 2; i++) idle(0);

    // Byte store match stalls until drained.
    cycle(1, 32'h500, 32'h22, 32'h000000AB, 1, 1, 0, '0);
    cycle(0, '0, '0, '0, 0, 1, 1, 32'h20);
    chk("sb_ld_stall", 32'(ld_stall), 32'h1);
    cycle(0, '0, '0, '0, 0, 0, 1, 32'h20);
    cycle(0, '0, '0, '0, 0, 0, 1, 32'h20);
    chk("sb_stall_clear", 32'(ld_stall), 32'h0);

    // Store pushed this cycle is invisible to the probe.
    cycle(1, 32'h600, 32'h30, 32'h33333333, 0, 1, 1, 32'h30);
    idle(0);

    // Asynchronous reset while three entries drain.
    for (int i = 0; i < 3; i++)
      cycle(1, 32'h700 + 32'(i), 32'h70 + 32'(i*4), 32'hE0 + 32'(i), 0, 1, 0, '0);
    drain_hold = 0; ld_valid = 1; ld_addr = 32'h70;
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) idle(0);

    // Random traffic over a small address window to provoke matches.
    for (int n = 0; n < 300; n++) begin
      logic        b;
      logic [31:0] a;
      b = 1'($urandom_range(0, 3) == 0);
      a = 32'h20 + 32'($urandom_range(0, 5) * 4) + (b ? 32'($urandom_range(0, 3)) : 32'h0);
      cycle(1'($urandom_range(0, 1)), $urandom, a, $urandom, b,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            32'h20 + 32'($urandom_range(0, 6) * 4) + 32'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
